// File: rtl/vec_dcache_port_arbiter.sv
// rtl/vec_dcache_port_arbiter.sv - shares one write-through data-cache request port between the scalar LSU and the vector unit
//
// Requests from NR_REQ requesters are arbitrated onto one cache port. Each request that wins the arbitration is
// tagged with a transaction ID (TID) from a free pool. Responses come back by TID, possibly out of order, and are
// routed to the requester that owns the TID. A flush/drain sequence stops granting until all TIDs are free.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i / req_ready_o          per-requester request handshake (ready is the combinational grant)
//   req_addr_i / req_we_i /
//   req_wdata_i / req_be_i             packed per-requester request fields
//   mem_req_valid_o / mem_req_ready_i  registered request to the cache
//   mem_addr_o / mem_we_o /
//   mem_wdata_o / mem_be_o / mem_tid_o forwarded request fields and allocated TID
//   mem_rsp_valid_i / mem_rsp_tid_i /
//   mem_rsp_rdata_i                    cache response (always accepted)
//   rsp_valid_o / rsp_rdata_o          one-hot response strobe and shared response data
//   flush_i                            stop granting and drain
//   idle_o                             nothing outstanding and nothing pending
//   tid_err_o                          sticky: response for a TID that was not allocated
//
// Build option: CVA6_ARB_SCALAR_PRIO_EN selects fixed priority (requester 0 always wins) instead of round-robin.

module vec_dcache_port_arbiter #(
    parameter int NR_REQ    = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int TID_W     = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NR_REQ-1:0]          req_valid_i,
    output logic [NR_REQ-1:0]          req_ready_o,
    input  logic [NR_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NR_REQ-1:0]          req_we_i,
    input  logic [NR_REQ*DATA_W-1:0]   req_wdata_i,
    input  logic [NR_REQ*DATA_W/8-1:0] req_be_i,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic                       mem_we_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [DATA_W/8-1:0]        mem_be_o,
    output logic [TID_W-1:0]           mem_tid_o,
    input  logic                       mem_rsp_valid_i,
    input  logic [TID_W-1:0]           mem_rsp_tid_i,
    input  logic [DATA_W-1:0]          mem_rsp_rdata_i,
    output logic [NR_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    input  logic                       flush_i,
    output logic                       idle_o,
    output logic                       tid_err_o
);

    localparam int NR_TID = 2 ** TID_W;
    localparam int OWN_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int BE_W   = DATA_W / 8;

    generate
        if (MAX_OUTST > NR_TID || MAX_OUTST < 1) begin : g_bad_cfg
            $error("vec_dcache_port_arbiter: MAX_OUTST must be in 1..2**TID_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_IDLE_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NR_TID-1:0]   busy_q, busy_d;
    logic [OWN_W-1:0]    owner_q [NR_TID];
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic                out_we_q;
    logic [DATA_W-1:0]   out_wdata_q;
    logic [BE_W-1:0]     out_be_q;
    logic [TID_W-1:0]    out_tid_q;

    logic [NR_REQ-1:0]   rsp_valid_q, rsp_onehot;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                tid_err_q;

    logic                win_found;
    logic [OWN_W-1:0]    win_idx;
    logic                free_found;
    logic [TID_W-1:0]    free_tid;
    logic                grant_en;
    logic                grant;
    logic                rsp_hit;
    logic [NR_TID-1:0]   free_mask, alloc_mask;

    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

`ifdef CVA6_ARB_SCALAR_PRIO_EN
    // Fixed priority: the lowest valid index wins, so the scalar LSU always goes first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(i);
            end
        end
    end
`else
    logic [OWN_W-1:0] rr_ptr_q;

    // Round-robin: scan from the pointer upwards, wrapping at NR_REQ.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NR_REQ) begin
                idx = idx - NR_REQ;
            end
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (win_idx == OWN_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    // Lowest free TID below MAX_OUTST. Uses the registered pool, so a TID freed this
    // cycle only becomes allocatable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_tid   = '0;
        for (int t = MAX_OUTST - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_found = 1'b1;
                free_tid   = TID_W'(t);
            end
        end
    end

    // Winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (win_idx == OWN_W'(i)) begin
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_we    = req_we_i[i];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                sel_be    = req_be_i[i*BE_W +: BE_W];
            end
        end
    end

    // FSM next state. Granting is also held off in the cycle flush_i rises so that
    // nothing new is issued once a drain has been requested.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                grant_en = !flush_i;
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    state_d = ST_IDLE_WAIT;
                end
            end
            ST_IDLE_WAIT: begin
                if (busy_q == '0 && !flush_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign grant = grant_en && win_found && free_found
                && (cnt_q < CNT_W'(MAX_OUTST))
                && (!out_valid_q || mem_req_ready_i);

    assign rsp_hit = mem_rsp_valid_i && busy_q[mem_rsp_tid_i];

    always_comb begin
        req_ready_o = '0;
        alloc_mask  = '0;
        free_mask   = '0;
        rsp_onehot  = '0;
        if (grant) begin
            req_ready_o[win_idx] = 1'b1;
            alloc_mask[free_tid] = 1'b1;
        end
        if (rsp_hit) begin
            free_mask[mem_rsp_tid_i]            = 1'b1;
            rsp_onehot[owner_q[mem_rsp_tid_i]]  = 1'b1;
        end
        busy_d = (busy_q & ~free_mask) | alloc_mask;
        cnt_d  = cnt_q;
        if (grant && !rsp_hit) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant && rsp_hit) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            busy_q      <= '0;
            cnt_q       <= '0;
            for (int t = 0; t < NR_TID; t++) begin
                owner_q[t] <= '0;
            end
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_we_q    <= 1'b0;
            out_wdata_q <= '0;
            out_be_q    <= '0;
            out_tid_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            tid_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_onehot;
            if (grant) begin
                owner_q[free_tid] <= win_idx;
                out_valid_q       <= 1'b1;
                out_addr_q        <= sel_addr;
                out_we_q          <= sel_we;
                out_wdata_q       <= sel_wdata;
                out_be_q          <= sel_be;
                out_tid_q         <= free_tid;
            end else if (mem_req_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (rsp_hit) begin
                rsp_rdata_q <= mem_rsp_rdata_i;
            end
            if (mem_rsp_valid_i && !busy_q[mem_rsp_tid_i]) begin
                tid_err_q <= 1'b1;
            end
        end
    end

    assign mem_req_valid_o = out_valid_q;
    assign mem_addr_o      = out_addr_q;
    assign mem_we_o        = out_we_q;
    assign mem_wdata_o     = out_wdata_q;
    assign mem_be_o        = out_be_q;
    assign mem_tid_o       = out_tid_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign tid_err_o       = tid_err_q;
    assign idle_o          = (cnt_q == '0) && !out_valid_q && !(|req_valid_i);

endmodule

// File: doc/vec_dcache_port_arbiter.md
Name: vec_dcache_port_arbiter

Overview:
Shares one write-through data-cache request port between the scalar load/store unit (requester 0) and the vector unit's memory interface (requester 1).
- Arbitrates requests and tags each grant with a transaction ID (TID) from a free pool.
- Returns responses, possibly out of order, to the owning requester by TID.
- Supports a flush/drain sequence, used before fence and before vector-unit reconfiguration.

Parameters:
NR_REQ, 2, number of requesters (index 0 = scalar LSU).
ADDR_W, 64, request address width.
DATA_W, 64, data width.
TID_W, 2, width of the cache transaction ID.
MAX_OUTST, 4, maximum in-flight transactions; must be <= 2**TID_W (elaboration error otherwise).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NR_REQ  per-requester request valid
req_ready_o  out  NR_REQ  per-requester grant (handshake = valid & ready)
req_addr_i  in  NR_REQ*ADDR_W  request addresses, packed
req_we_i  in  NR_REQ  write enable
req_wdata_i  in  NR_REQ*DATA_W  write data
req_be_i  in  NR_REQ*DATA_W/8  byte enables
mem_req_valid_o  out  1  request to cache
mem_req_ready_i  in  1  cache accepts
mem_addr_o / mem_we_o / mem_wdata_o / mem_be_o  out  ADDR_W/1/DATA_W/DATA_W/8  forwarded fields
mem_tid_o  out  TID_W  allocated TID
mem_rsp_valid_i  in  1  cache response valid (always accepted)
mem_rsp_tid_i  in  TID_W  response TID
mem_rsp_rdata_i  in  DATA_W  read data
rsp_valid_o  out  NR_REQ  one-hot response strobe
rsp_rdata_o  out  DATA_W  response data, shared by all requesters
flush_i  in  1  stop granting and drain
idle_o  out  1  no transactions outstanding and nothing pending
tid_err_o  out  1  sticky: a response arrived for a TID that was not allocated

Behaviour:
Reset values: all outputs 0 except idle_o=1. Reset clears the owner table, the free pool (all TIDs free), the round-robin pointer (0), tid_err_o, and the FSM (RUN). Reset during outstanding transactions drops them silently.

FSM states and transitions:
- RUN -> DRAIN when flush_i=1.
- DRAIN -> IDLE_WAIT when no transaction is held on the output register.
- IDLE_WAIT -> RUN when all TIDs are free and flush_i=0.
- DRAIN and IDLE_WAIT grant nothing.

Output register:
- One-entry register with valid/ready semantics.
- A held request keeps mem_req_valid_o and all fields stable until mem_req_ready_i=1. Flush does not retract it.

Grant conditions (RUN only): register empty, or emptying this cycle; at least one TID free; outstanding count < MAX_OUTST.

Arbitration and grant:
- Round-robin among valid requesters, starting at the pointer.
- On a grant, the pointer moves to (winner+1) mod NR_REQ.
- req_ready_o is asserted combinationally, to the winner only.
- Grant-to-mem_req_valid_o latency: 1 cycle.

TID allocation:
- The lowest-index free TID below MAX_OUTST is allocated.
- The winner index is recorded in the owner table and the TID is marked busy.

Responses:
- rsp_valid_o[owner[tid]] and rsp_rdata_o are registered, so latency is 1 cycle after mem_rsp_valid_i. The TID is freed in that same cycle.
- A response is accepted every cycle; there is no backpressure.
- A response for a free TID: rsp_valid_o stays 0, tid_err_o is set and cleared only by reset.

Simultaneous events:
- A TID freed in cycle N is allocatable from cycle N+1, never in N.
- Allocation and free of different TIDs in the same cycle are both honoured.
- Counter arithmetic uses clog2(MAX_OUTST+1) bits and never wraps.

idle_o = outstanding count==0 & output register empty & no req_valid_i.

Optional Feature:
Macro CVA6_ARB_SCALAR_PRIO_EN.
- Defined: fixed priority with requester 0 always winning. The vector requester is granted only when requester 0 is not valid. The round-robin pointer is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Both requesters valid every cycle, cache always ready → grants alternate 0,1,0,1; mem_tid_o = 0,1,2,3; no grant in cycle 5 until a response frees a TID.
- Four reads outstanding (TID0=req0, TID1=req1, TID2=req0, TID3=req1); responses in TID order 3,0,2,1 with rdata=0xA3,0xA0,0xA2,0xA1 → rsp_valid_o = 2'b10,01,01,10 one cycle later, carrying the matching data.
- Cache ready held 0 for 5 cycles with a request in the register → mem_addr_o, mem_tid_o and data stable; no further req_ready_o; handshake completes on the first cycle ready=1.
- flush_i pulsed with 2 outstanding → no grants; idle_o=1 one cycle after the final response is delivered; granting resumes in RUN once flush_i=0.
- mem_rsp_valid_i with TID 2 while TID 2 is free → rsp_valid_o=0, tid_err_o=1 and held until rst_ni asserted.
- Under CVA6_ARB_SCALAR_PRIO_EN, both requesters always valid → only requester 0 granted; requester 1 granted in the first cycle req_valid_i[0]=0.
